nanosoc_dma_trace_buffer: RTL and testbench

Synthesizable, parametrised on-chip trace capture for the PL230 DMA subsystem. It passively monitors the DMA AHB manager port, the DMA APB control port and the DMA request/status signals. Each qualifying event becomes one timestamped record in a circular trace store. Software or a debug host drains the store through a valid/ready port, so DMA integration can be traced on silicon and FPGA, not only in simulation logs.

---
 rtl/nanosoc_dma_trace_pkg.sv | 38 +++
 rtl/nanosoc_dma_trace_fifo.sv | 85 ++++++++
 rtl/nanosoc_dma_trace_buffer.sv | 239 +++++++++++++++++++++++
 tb/tb_nanosoc_dma_trace_buffer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nanosoc_dma_trace_pkg.sv
// Shared encodings for the DMA trace buffer: record type codes and PL230 controller states.
// Timestamp capture is enabled by defining NANOSOC_DMA_TRACE_TS_EN.
package nanosoc_dma_trace_pkg;

  typedef enum logic [1:0] {
    TRC_AHB   = 2'd0,
    TRC_APB   = 2'd1,
    TRC_STATE = 2'd2,
    TRC_IO    = 2'd3
  } trc_type_e;

  typedef enum logic [3:0] {
    PL230_IDLE         = 4'd0,
    PL230_RD_CTRL      = 4'd1,
    PL230_RD_SRC_PTR   = 4'd2,
    PL230_RD_DST_PTR   = 4'd3,
    PL230_RD_SRC_DATA  = 4'd4,
    PL230_WR_DST_DATA  = 4'd5,
    PL230_WAIT_REQ_CLR = 4'd6,
    PL230_WR_CTRL      = 4'd7,
    PL230_STALLED      = 4'd8,
    PL230_DONE         = 4'd9,
    PL230_PSGATHER     = 4'd10,
    PL230_RSVD_11      = 4'd11,
    PL230_RSVD_12      = 4'd12,
    PL230_RSVD_13      = 4'd13,
    PL230_RSVD_14      = 4'd14,
    PL230_UNDEF        = 4'd15
  } pl230_state_e;

  // Controller states that never drive the bus: 0, 6, 8, 9, 10, 15.
  localparam logic [15:0] NO_BUS_STATES = 16'h8741;

  function automatic logic is_no_bus(input logic [3:0] state);
    return NO_BUS_STATES[state];
  endfunction

endpackage

// File: rtl/nanosoc_dma_trace_fifo.sv
// Circular trace store with stop/overwrite policy, sticky overflow and saturating drop count.
// Record width is set by the parent; NANOSOC_DMA_TRACE_TS_EN only changes that width.
module nanosoc_dma_trace_fifo #(
  parameter int REC_W      = 8,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [REC_W-1:0]      wr_rec,
  input  logic                  wrap,
  input  logic [1:0]            lose_cnt,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [REC_W-1:0]      rd_rec,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  overflow,
  output logic [7:0]            drop_cnt
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [REC_W-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg, count_next;
  logic                  overflow_reg;
  logic [7:0]            drop_reg, drop_next;
  logic [8:0]            drop_sum;
  logic                  do_pop, overrun, do_write, advance_rd;

  assign full     = (count_reg == FULL_CNT);
  assign rd_valid = (count_reg != '0);
  assign do_pop   = rd_valid & rd_ready;
  // A full store with a simultaneous pop always has room for the new record.
  assign overrun    = wr_en & full & ~do_pop;
  assign do_write   = wr_en & (~overrun | wrap);
  assign advance_rd = do_pop | (overrun & wrap);

  always_comb begin
    count_next = count_reg;
    if (do_write && !advance_rd)
      count_next = count_reg + 1'b1;
    else if (!do_write && advance_rd)
      count_next = count_reg - 1'b1;
  end

  assign drop_sum  = 9'(drop_reg) + 9'(lose_cnt) + 9'(overrun);
  assign drop_next = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      drop_reg     <= '0;
    end else if (clear) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      drop_reg     <= '0;
    end else begin
      if (do_write)   wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (advance_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      if (overrun) overflow_reg <= 1'b1;
      drop_reg <= drop_next;
    end
  end

  always_ff @(posedge hclk) begin
    if (do_write && !clear)
      mem[wr_ptr_reg] <= wr_rec;
  end

  assign rd_rec   = mem[rd_ptr_reg];
  assign count    = count_reg;
  assign overflow = overflow_reg;
  assign drop_cnt = drop_reg;

endmodule

// File: rtl/nanosoc_dma_trace_buffer.sv
// DMA trace capture: AHB de-pipelining, APB/state/IO event detection and arbitration into the store.
// Define NANOSOC_DMA_TRACE_TS_EN to timestamp records; otherwise rd_ts is tied to 0.
module nanosoc_dma_trace_buffer
  import nanosoc_dma_trace_pkg::*;
#(
  parameter int NUM_CHNLS     = 2,
  parameter int NUM_CHNL_BITS = 1,
  parameter int DATA_W        = 32,
  parameter int DEPTH_LOG2    = 5,
  parameter int TS_W          = 16
) (
  input  logic                     hclk,
  input  logic                     hresetn,
  input  logic                     hready,
  input  logic                     hwrite,
  input  logic [1:0]               htrans,
  input  logic [2:0]               hsize,
  input  logic [31:0]              haddr,
  input  logic [DATA_W-1:0]        hwdata,
  input  logic [DATA_W-1:0]        hrdata,
  input  logic                     pclken,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [11:0]              paddr,
  input  logic [31:0]              pwdata,
  input  logic [31:0]              prdata,
  input  logic [NUM_CHNLS-1:0]     dma_req,
  input  logic [NUM_CHNLS-1:0]     dma_active,
  input  logic [NUM_CHNLS-1:0]     dma_done,
  input  logic [NUM_CHNL_BITS-1:0] dma_chnl,
  input  logic [3:0]               dma_ctrl_state,
  input  logic                     trc_enable,
  input  logic                     trc_wrap,
  input  logic [3:0]               trc_filter,
  input  logic                     trc_clear,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [1:0]               rd_type,
  output logic [NUM_CHNL_BITS-1:0] rd_chnl,
  output logic [3:0]               rd_state,
  output logic                     rd_wr,
  output logic [DATA_W/8-1:0]      rd_lanes,
  output logic [31:0]              rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [TS_W-1:0]          rd_ts,
  output logic [DEPTH_LOG2:0]      trc_count,
  output logic                     trc_full,
  output logic                     trc_overflow,
  output logic [7:0]               trc_drop_cnt
);

  localparam int LANES  = DATA_W / 8;
  localparam int LB     = $clog2(LANES);
  localparam int BASE_W = 2 + NUM_CHNL_BITS + 4 + 1 + LANES + 32 + DATA_W;
`ifdef NANOSOC_DMA_TRACE_TS_EN
  localparam int REC_W  = BASE_W + TS_W;
`else
  localparam int REC_W  = BASE_W;
`endif

  // Lane gi is active when it falls in the same size-aligned block as the address.
  logic [LANES-1:0] lane_dec;
  genvar gi;
  for (gi = 0; gi < LANES; gi++) begin : g_lane
    localparam logic [LB-1:0] LANE_IDX = LB'(gi);
    assign lane_dec[gi] = ((LANE_IDX >> hsize) == (haddr[LB-1:0] >> hsize));
  end

  logic                     aph_valid_reg, aph_write_reg;
  logic [31:0]              aph_addr_reg;
  logic [LANES-1:0]         aph_lanes_reg;
  logic [NUM_CHNL_BITS-1:0] aph_chnl_reg;
  logic [3:0]               aph_state_reg;
  logic [3:0]               state_last_reg;
  logic [NUM_CHNLS-1:0]     req_last_reg, active_last_reg, done_last_reg;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      aph_valid_reg   <= 1'b0;
      aph_write_reg   <= 1'b0;
      aph_addr_reg    <= '0;
      aph_lanes_reg   <= '0;
      aph_chnl_reg    <= '0;
      aph_state_reg   <= '0;
      state_last_reg  <= '0;
      req_last_reg    <= '0;
      active_last_reg <= '0;
      done_last_reg   <= '0;
    end else begin
      if (hready) begin
        aph_valid_reg <= htrans[1];
        if (htrans[1]) begin
          aph_write_reg <= hwrite;
          aph_addr_reg  <= haddr;
          aph_lanes_reg <= lane_dec;
          aph_chnl_reg  <= dma_chnl;
          aph_state_reg <= dma_ctrl_state;
        end
      end
      state_last_reg  <= dma_ctrl_state;
      req_last_reg    <= dma_req;
      active_last_reg <= dma_active;
      done_last_reg   <= dma_done;
    end
  end

  logic unused_htrans;
  assign unused_htrans = htrans[0];

  function automatic logic [NUM_CHNL_BITS-1:0] lowest_active(input logic [NUM_CHNLS-1:0] v);
    lowest_active = '0;
    for (int i = NUM_CHNLS - 1; i >= 0; i--)
      if (v[i]) lowest_active = NUM_CHNL_BITS'(i);
  endfunction

  logic       ahb_evt, apb_evt, state_evt, io_evt;
  logic [3:0] evt_q;
  logic [2:0] evt_num;
  logic [1:0] lose_cnt;
  logic       wr_en;

  assign ahb_evt   = aph_valid_reg & hready;
  assign apb_evt   = pclken & psel & penable;
  assign state_evt = (dma_ctrl_state != state_last_reg) & is_no_bus(dma_ctrl_state);
  assign io_evt    = (dma_req != req_last_reg)
                   | ((dma_active != active_last_reg) & (|dma_active))
                   | ((dma_done != done_last_reg) & (|dma_done));

  assign evt_q    = {io_evt, state_evt, apb_evt, ahb_evt} & trc_filter & {4{trc_enable}};
  assign evt_num  = 3'(evt_q[0]) + 3'(evt_q[1]) + 3'(evt_q[2]) + 3'(evt_q[3]);
  assign wr_en    = (|evt_q) & ~trc_clear;
  assign lose_cnt = (trc_clear || evt_num == 3'd0) ? 2'd0 : 2'(evt_num - 3'd1);

  trc_type_e                sel_type;
  logic [NUM_CHNL_BITS-1:0] sel_chnl;
  logic [3:0]               sel_state;
  logic                     sel_wr;
  logic [LANES-1:0]         sel_lanes;
  logic [31:0]              sel_addr;
  logic [DATA_W-1:0]        sel_data;

  always_comb begin
    sel_type  = TRC_AHB;
    sel_chnl  = '0;
    sel_state = '0;
    sel_wr    = 1'b0;
    sel_lanes = '0;
    sel_addr  = '0;
    sel_data  = '0;
    if (evt_q[0]) begin
      sel_chnl  = aph_chnl_reg;
      sel_state = aph_state_reg;
      sel_wr    = aph_write_reg;
      sel_lanes = aph_lanes_reg;
      sel_addr  = aph_addr_reg;
      sel_data  = aph_write_reg ? hwdata : hrdata;
    end else if (evt_q[1]) begin
      sel_type  = TRC_APB;
      sel_chnl  = dma_chnl;
      sel_state = dma_ctrl_state;
      sel_wr    = pwrite;
      sel_addr  = {20'd0, paddr};
      sel_data  = DATA_W'(pwrite ? pwdata : prdata);
    end else if (evt_q[2]) begin
      sel_type  = TRC_STATE;
      sel_chnl  = dma_chnl;
      sel_state = dma_ctrl_state;
    end else if (evt_q[3]) begin
      sel_type  = TRC_IO;
      sel_chnl  = lowest_active(dma_active);
      sel_state = dma_ctrl_state;
      sel_addr  = 32'({dma_done, dma_active, dma_req});
    end
  end

  logic [BASE_W-1:0] rec_base;
  logic [REC_W-1:0]  wr_rec, rd_rec;
  logic [TS_W-1:0]   head_ts;
  logic              fifo_valid;

  assign rec_base = {sel_type, sel_chnl, sel_state, sel_wr, sel_lanes, sel_addr, sel_data};

`ifdef NANOSOC_DMA_TRACE_TS_EN
  logic [TS_W-1:0] ts_reg;
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)       ts_reg <= '0;
    else if (trc_clear) ts_reg <= '0;
    else                ts_reg <= ts_reg + 1'b1;
  end
  assign wr_rec  = {ts_reg, rec_base};
  assign head_ts = rd_rec[REC_W-1 -: TS_W];
`else
  assign wr_rec  = rec_base;
  assign head_ts = '0;
`endif

  nanosoc_dma_trace_fifo #(
    .REC_W      (REC_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .clear    (trc_clear),
    .wr_en    (wr_en),
    .wr_rec   (wr_rec),
    .wrap     (trc_wrap),
    .lose_cnt (lose_cnt),
    .rd_ready (rd_ready),
    .rd_valid (fifo_valid),
    .rd_rec   (rd_rec),
    .count    (trc_count),
    .full     (trc_full),
    .overflow (trc_overflow),
    .drop_cnt (trc_drop_cnt)
  );

  logic [1:0]               h_type;
  logic [NUM_CHNL_BITS-1:0] h_chnl;
  logic [3:0]               h_state;
  logic                     h_wr;
  logic [LANES-1:0]         h_lanes;
  logic [31:0]              h_addr;
  logic [DATA_W-1:0]        h_data;

  assign {h_type, h_chnl, h_state, h_wr, h_lanes, h_addr, h_data} = rd_rec[BASE_W-1:0];

  // Stale store contents never leak out while the store is empty.
  assign rd_valid = fifo_valid;
  assign rd_type  = fifo_valid ? h_type  : '0;
  assign rd_chnl  = fifo_valid ? h_chnl  : '0;
  assign rd_state = fifo_valid ? h_state : '0;
  assign rd_wr    = fifo_valid ? h_wr    : 1'b0;
  assign rd_lanes = fifo_valid ? h_lanes : '0;
  assign rd_addr  = fifo_valid ? h_addr  : '0;
  assign rd_data  = fifo_valid ? h_data  : '0;
  assign rd_ts    = fifo_valid ? head_ts : '0;

endmodule

// File: tb/tb_nanosoc_dma_trace_buffer.sv
// Directed scoreboard bench for nanosoc_dma_trace_buffer (depth 4, 32-bit data, 2 channels).
module tb_nanosoc_dma_trace_buffer;

  localparam int NUM_CHNLS     = 2;
  localparam int NUM_CHNL_BITS = 1;
  localparam int DATA_W        = 32;
  localparam int DEPTH_LOG2    = 2;
  localparam int TS_W          = 16;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hready, hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] haddr, hwdata, hrdata;
  logic        pclken, psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic [1:0]  dma_req, dma_active, dma_done;
  logic [0:0]  dma_chnl;
  logic [3:0]  dma_ctrl_state;
  logic        trc_enable, trc_wrap, trc_clear;
  logic [3:0]  trc_filter;
  logic        rd_valid, rd_ready;
  logic [1:0]  rd_type;
  logic [0:0]  rd_chnl;
  logic [3:0]  rd_state;
  logic        rd_wr;
  logic [3:0]  rd_lanes;
  logic [31:0] rd_addr, rd_data;
  logic [15:0] rd_ts;
  logic [2:0]  trc_count;
  logic        trc_full, trc_overflow;
  logic [7:0]  trc_drop_cnt;

  typedef struct packed {
    logic [1:0]  typ;
    logic [0:0]  chnl;
    logic [3:0]  state;
    logic        wr;
    logic [3:0]  lanes;
    logic [31:0] addr;
    logic [31:0] data;
  } rec_t;

  rec_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  nanosoc_dma_trace_buffer #(
    .NUM_CHNLS(NUM_CHNLS), .NUM_CHNL_BITS(NUM_CHNL_BITS), .DATA_W(DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2), .TS_W(TS_W)
  ) dut (
    .hclk(hclk), .hresetn(hresetn), .hready(hready), .hwrite(hwrite), .htrans(htrans),
    .hsize(hsize), .haddr(haddr), .hwdata(hwdata), .hrdata(hrdata),
    .pclken(pclken), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .dma_req(dma_req), .dma_active(dma_active),
    .dma_done(dma_done), .dma_chnl(dma_chnl), .dma_ctrl_state(dma_ctrl_state),
    .trc_enable(trc_enable), .trc_wrap(trc_wrap), .trc_filter(trc_filter),
    .trc_clear(trc_clear), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_type(rd_type),
    .rd_chnl(rd_chnl), .rd_state(rd_state), .rd_wr(rd_wr), .rd_lanes(rd_lanes),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_ts(rd_ts), .trc_count(trc_count),
    .trc_full(trc_full), .trc_overflow(trc_overflow), .trc_drop_cnt(trc_drop_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  function automatic rec_t mk(input logic [1:0] typ, input logic chnl, input logic [3:0] st,
                              input logic wr, input logic [3:0] lanes,
                              input logic [31:0] addr, input logic [31:0] data);
    rec_t r;
    r.typ = typ; r.chnl = chnl; r.state = st; r.wr = wr;
    r.lanes = lanes; r.addr = addr; r.data = data;
    return r;
  endfunction

  // Pops n expected records, comparing each against the presented head before popping it.
  task automatic drain(input int n, input string tag);
    rec_t e;
    for (int i = 0; i < n; i++) begin
      e = sb.pop_front();
      chk($sformatf("%s%0d_valid", tag, i), rd_valid, 1'b1);
      chk($sformatf("%s%0d_type", tag, i), rd_type, e.typ);
      chk($sformatf("%s%0d_chnl", tag, i), rd_chnl, e.chnl);
      chk($sformatf("%s%0d_state", tag, i), rd_state, e.state);
      chk($sformatf("%s%0d_wr", tag, i), rd_wr, e.wr);
      chk($sformatf("%s%0d_lanes", tag, i), rd_lanes, e.lanes);
      chk($sformatf("%s%0d_addr", tag, i), rd_addr, e.addr);
      chk($sformatf("%s%0d_data", tag, i), rd_data, e.data);
`ifndef NANOSOC_DMA_TRACE_TS_EN
      chk($sformatf("%s%0d_ts", tag, i), rd_ts, 16'h0);
`endif
      $display("drain %s%0d type=%0d addr=%08h data=%08h", tag, i, rd_type, rd_addr, rd_data);
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
    end
  endtask

  task automatic ahb(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                     input logic [31:0] data, input logic [3:0] lanes, input logic apb_hit);
    sb.push_back(mk(2'd0, dma_chnl, dma_ctrl_state, wr, lanes, addr, data));
    htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size;
    step();
    htrans = 2'b00;
    if (wr) hwdata = data; else hrdata = data;
    if (apb_hit) begin
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h028; pwdata = 32'h3;
    end
    step();
    psel = 1'b0; penable = 1'b0;
    $display("ahb addr=%08h wr=%0b data=%08h apb=%0b", addr, wr, data, apb_hit);
  endtask

  task automatic apb(input logic [11:0] addr, input logic wr, input logic [31:0] data,
                     input logic expect_rec);
    if (expect_rec)
      sb.push_back(mk(2'd1, dma_chnl, dma_ctrl_state, wr, 4'h0, {20'd0, addr}, data));
    psel = 1'b1; penable = 1'b1; pwrite = wr; paddr = addr;
    if (wr) pwdata = data; else prdata = data;
    step();
    psel = 1'b0; penable = 1'b0;
    $display("apb addr=%03h wr=%0b data=%08h expect=%0b", addr, wr, data, expect_rec);
  endtask

  task automatic pulse_clear();
    trc_clear = 1'b1;
    step();
    trc_clear = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, rd_valid, 1'b0);
    chk({tag, "_count"}, trc_count, 3'd0);
    chk({tag, "_full"}, trc_full, 1'b0);
    chk({tag, "_ovf"}, trc_overflow, 1'b0);
    chk({tag, "_drop"}, trc_drop_cnt, 8'd0);
    chk({tag, "_type"}, rd_type, 2'd0);
    chk({tag, "_addr"}, rd_addr, 32'd0);
    chk({tag, "_data"}, rd_data, 32'd0);
    chk({tag, "_ts"}, rd_ts, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

  initial begin
    hresetn = 1'b0; hready = 1'b1; hwrite = 1'b0; htrans = 2'b00; hsize = 3'd2;
    haddr = '0; hwdata = '0; hrdata = '0;
    pclken = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
    pwdata = '0; prdata = '0;
    dma_req = '0; dma_active = '0; dma_done = '0; dma_chnl = '0; dma_ctrl_state = 4'd0;
    trc_enable = 1'b1; trc_wrap = 1'b0; trc_filter = 4'hF; trc_clear = 1'b0; rd_ready = 1'b0;
    repeat (3) @(posedge hclk);
    #1;
    chk_idle_outputs("reset");
    hresetn = 1'b1;
    step();

    // AHB word write and byte/halfword lane decode
    dma_chnl = 1'b1;
    ahb(32'h2000_0010, 1'b1, 3'd2, 32'hDEAD_BEEF, 4'hF, 1'b0);
    chk("t1_count", trc_count, 3'd1);
    drain(sb.size(), "t1_");
    dma_chnl = 1'b0;
    ahb(32'h2000_0023, 1'b0, 3'd0, 32'h1122_3344, 4'h8, 1'b0);
    ahb(32'h2000_0006, 1'b1, 3'd1, 32'hCAFE_0000, 4'hC, 1'b0);
    chk("t2_count", trc_count, 3'd2);
    drain(sb.size(), "t2_");
    chk("t2_empty", rd_valid, 1'b0);

    // APB collides with an AHB completion: AHB wins
    ahb(32'h2000_0100, 1'b1, 3'd2, 32'h0000_00A5, 4'hF, 1'b1);
    chk("t3_count", trc_count, 3'd1);
    chk("t3_drop", trc_drop_cnt, 8'd1);
    drain(sb.size(), "t3_");

    // Filtered and disabled events are neither stored nor counted
    trc_filter = 4'b1101;
    apb(12'h010, 1'b1, 32'h55, 1'b0);
    chk("filt_count", trc_count, 3'd0);
    chk("filt_drop", trc_drop_cnt, 8'd1);
    trc_filter = 4'hF; trc_enable = 1'b0;
    apb(12'h014, 1'b1, 32'h66, 1'b0);
    chk("dis_count", trc_count, 3'd0);
    trc_enable = 1'b1;

    // IO event: channel 1 goes active, then inactive (no record)
    sb.push_back(mk(2'd3, 1'b1, 4'd0, 1'b0, 4'h0, 32'h0000_0008, 32'h0));
    dma_active = 2'b10;
    step();
    chk("io_count", trc_count, 3'd1);
    dma_active = 2'b00;
    step();
    chk("io_idle_count", trc_count, 3'd1);
    drain(sb.size(), "io_");

    // Stop-when-full: 6 events into 4 slots
    pulse_clear();
    chk("clr_drop", trc_drop_cnt, 8'd0);
    trc_wrap = 1'b0;
    for (int i = 0; i < 6; i++) apb(12'(16 * i), 1'b1, 32'(100 + i), i < 4);
    chk("stop_count", trc_count, 3'd4);
    chk("stop_full", trc_full, 1'b1);
    chk("stop_drop", trc_drop_cnt, 8'd2);
    chk("stop_ovf", trc_overflow, 1'b1);
    drain(sb.size(), "stop_");
    chk("stop_after_count", trc_count, 3'd0);

    // Overwrite-oldest: events 3..6 survive
    pulse_clear();
    chk("clr_ovf", trc_overflow, 1'b0);
    trc_wrap = 1'b1;
    for (int i = 0; i < 6; i++) apb(12'(16 * i + 4), 1'b1, 32'(200 + i), i >= 2);
    chk("wrap_count", trc_count, 3'd4);
    chk("wrap_full", trc_full, 1'b1);
    chk("wrap_drop", trc_drop_cnt, 8'd2);
    chk("wrap_ovf", trc_overflow, 1'b1);
    drain(sb.size(), "wrap_");

    // State changes 0 -> 1 -> 9: only 9 is recorded
    pulse_clear();
    trc_wrap = 1'b0;
    dma_ctrl_state = 4'd1;
    step();
    chk("st1_count", trc_count, 3'd0);
    sb.push_back(mk(2'd2, 1'b0, 4'd9, 1'b0, 4'h0, 32'h0, 32'h0));
    dma_ctrl_state = 4'd9;
    step();
    chk("st9_count", trc_count, 3'd1);
    drain(sb.size(), "st_");
    dma_ctrl_state = 4'd6;
    pulse_clear();
    chk("clrcyc_count", trc_count, 3'd0);
    chk("clrcyc_valid", rd_valid, 1'b0);

    // Reset mid-drain; the second APB event also beats a state change
    apb(12'h004, 1'b1, 32'h1, 1'b1);
    dma_ctrl_state = 4'd0;
    apb(12'h008, 1'b1, 32'h2, 1'b1);
    chk("pre_rst_count", trc_count, 3'd2);
    chk("pre_rst_drop", trc_drop_cnt, 8'd1);
    drain(1, "mid_");
    chk("mid_count", trc_count, 3'd1);
    sb.delete();
    hresetn = 1'b0;
    #1;
    chk_idle_outputs("async_rst");
    @(negedge hclk);
    hresetn = 1'b1;
    step();
    chk("post_rst_valid", rd_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
